// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
// mem_access_unit
// Owns MAR and MDR and runs variable-latency read/write transactions
// against an external memory port. An access is started with mio_en
// (r_w sampled alongside), the request is held until mem_ack or until a
// programmable timeout expires, and completion is signalled by a
// one-cycle ready pulse. err reports that the last access timed out.
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   bus_in              global bus value (MAR takes the low ADDR_SIZE bits)
//   ld_mar, ld_mdr      load MAR / MDR from bus_in (idle only)
//   gate_mdr            drive MDR onto bus_out
//   bus_out, bus_out_en MDR (or 0) and its tristate enable
//   mio_en, r_w         start an access; 0 = read, 1 = write
//   ready, err, busy    completion pulse, timeout flag, not-idle
//   mem_addr, mem_wdata MAR and MDR towards memory
//   mem_req, mem_we     request (held until ack) and write strobe
//   mem_rdata, mem_ack  read data and completion from memory
module mem_access_unit #(
  parameter int WORDSIZE  = 16,
  parameter int ADDR_SIZE = 16,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WORDSIZE-1:0]  bus_in,
  input  logic                 ld_mar,
  input  logic                 ld_mdr,
  input  logic                 gate_mdr,
  output logic [WORDSIZE-1:0]  bus_out,
  output logic                 bus_out_en,
  input  logic                 mio_en,
  input  logic                 r_w,
  output logic                 ready,
  output logic                 err,
  output logic                 busy,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORDSIZE-1:0]  mem_wdata,
  output logic                 mem_req,
  output logic                 mem_we,
  input  logic [WORDSIZE-1:0]  mem_rdata,
  input  logic                 mem_ack
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  // Last counter value on which a missing ack aborts the access; the
  // request is therefore held for exactly TIMEOUT cycles.
  localparam logic [CNT_W-1:0] CNT_LIMIT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] mar_q, mar_d;
  logic [WORDSIZE-1:0]  mdr_q, mdr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 we_q, we_d;
  logic [ADDR_SIZE-1:0] bus_addr;

  // MAR view of the bus: truncate a wider bus, zero-extend a narrower one.
  generate
    if (ADDR_SIZE <= WORDSIZE) begin : g_addr_trunc
      assign bus_addr = bus_in[ADDR_SIZE-1:0];
    end else begin : g_addr_ext
      assign bus_addr = {{(ADDR_SIZE-WORDSIZE){1'b0}}, bus_in};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    we_d    = we_q;

    case (state_q)
      IDLE: begin
        // A start takes priority: the access uses the MAR/MDR held
        // before this edge, so bus loads in the same cycle are dropped.
        if (mio_en) begin
          we_d    = r_w;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = REQ;
        end else begin
          if (ld_mar) mar_d = bus_addr;
          if (ld_mdr) mdr_d = bus_in;
        end
      end
      REQ: begin
        // An ack on the limit cycle still counts as a success.
        if (mem_ack) begin
          state_d = DONE;
          if (!we_q) mdr_d = mem_rdata;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LIMIT)) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          // With the timeout disabled this may wrap; nothing observes it.
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    ready      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    bus_out    = '0;
    bus_out_en = gate_mdr;

    if (state_q == REQ) begin
      mem_req = 1'b1;
      mem_we  = we_q;
    end
    if (state_q == DONE) ready = 1'b1;
    if (state_q != IDLE) busy  = 1'b1;
    if (gate_mdr) bus_out = mdr_q;
  end

  assign err       = err_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
module tb_mem_access_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bus_in;
  logic        ld_mar, ld_mdr, gate_mdr;
  logic [15:0] bus_out;
  logic        bus_out_en;
  logic        mio_en, r_w;
  logic        ready, err, busy;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_req, mem_we;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  mem_access_unit #(
    .WORDSIZE (16),
    .ADDR_SIZE(16),
    .TIMEOUT  (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_in    (bus_in),
    .ld_mar    (ld_mar),
    .ld_mdr    (ld_mdr),
    .gate_mdr  (gate_mdr),
    .bus_out   (bus_out),
    .bus_out_en(bus_out_en),
    .mio_en    (mio_en),
    .r_w       (r_w),
    .ready     (ready),
    .err       (err),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  // Expected outcome of one access, queued when the access is issued.
  typedef struct {
    logic [15:0] mar;
    logic [15:0] mdr_old;
    logic [15:0] mdr_new;
    logic        we;
    logic        err;
    int unsigned cycles;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int unsigned n_vec = 0;
  int unsigned n_mis = 0;
  int unsigned req_cnt = 0;

  // Architectural reference state
  logic [15:0] m_mar, m_mdr;
  logic        m_err;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Monitor: checks the request phase against the head of the queue and
  // pops one expectation per ready pulse.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      req_cnt = 0;
    end else begin
      if (mem_req === 1'b1) begin
        req_cnt++;
        if (q.size() > 0) begin
          check("req_addr",  32'(mem_addr),  32'(q[0].mar));
          check("req_we",    32'(mem_we),    32'(q[0].we));
          check("req_wdata", 32'(mem_wdata), 32'(q[0].mdr_old));
          check("req_err",   32'(err),       32'd0);
          check("req_ready", 32'(ready),     32'd0);
        end
      end
      if (ready !== 1'b0) begin
        if (q.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL ready_unexpected: got ready=%b, required no pulse", ready);
        end else begin
          mon_e = q.pop_front();
          check("done_err",    32'(err),       32'(mon_e.err));
          check("done_mdr",    32'(mem_wdata), 32'(mon_e.mdr_new));
          check("done_addr",   32'(mem_addr),  32'(mon_e.mar));
          check("done_cycles", req_cnt,        mon_e.cycles);
          check("done_req",    32'(mem_req),   32'd0);
          check("done_busy",   32'(busy),      32'd1);
        end
        req_cnt = 0;
      end
    end
  end

  // All stimulus tasks start and end just after a rising edge.
  task automatic load(input logic lm, input logic ld, input logic [15:0] v);
    ld_mar = lm; ld_mdr = ld; bus_in = v; mio_en = 1'b0;
    @(posedge clk); #1;
    ld_mar = 1'b0; ld_mdr = 1'b0;
    if (lm) m_mar = v;
    if (ld) m_mdr = v;
  endtask

  task automatic access(input logic rw, input int unsigned waits,
                        input logic [15:0] rdata, input logic [15:0] junk);
    exp_t e;
    bit ok;
    int unsigned n;
    ok = (TMO == 0) || (waits < TMO);
    n  = ok ? waits + 1 : TMO;
    e.mar = m_mar; e.mdr_old = m_mdr; e.we = rw; e.err = !ok; e.cycles = n;
    e.mdr_new = (ok && !rw) ? rdata : m_mdr;
    q.push_back(e);
    m_mdr = e.mdr_new;
    m_err = !ok;
    // Loads in the start cycle must lose to mio_en.
    mio_en = 1'b1; r_w = rw; ld_mar = 1'b1; ld_mdr = 1'b1; bus_in = junk;
    @(posedge clk); #1;
    for (int unsigned k = 0; k < n; k++) begin
      mem_ack   = ok && (k == waits);
      mem_rdata = mem_ack ? rdata : 16'($urandom);
      mio_en    = 1'($urandom);
      ld_mar    = 1'($urandom);
      ld_mdr    = 1'($urandom);
      r_w       = 1'($urandom);
      bus_in    = 16'($urandom);
      @(posedge clk); #1;
    end
    mem_ack = 1'b0; mio_en = 1'b0; ld_mar = 1'b0; ld_mdr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle_check(input logic g);
    gate_mdr = g;
    @(negedge clk);
    check("idle_busy",   32'(busy),       32'd0);
    check("idle_ready",  32'(ready),      32'd0);
    check("idle_req",    32'(mem_req),    32'd0);
    check("idle_mar",    32'(mem_addr),   32'(m_mar));
    check("idle_mdr",    32'(mem_wdata),  32'(m_mdr));
    check("idle_err",    32'(err),        32'(m_err));
    check("idle_bus_en", 32'(bus_out_en), 32'(g));
    check("idle_bus",    32'(bus_out),    g ? 32'(m_mdr) : 32'd0);
    @(posedge clk); #1;
    gate_mdr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; bus_in = '0; ld_mar = 1'b0; ld_mdr = 1'b0; gate_mdr = 1'b0;
    mio_en = 1'b0; r_w = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    m_mar = '0; m_mdr = '0; m_err = 1'b0;

    // Reset with random inputs
    repeat (3) begin
      bus_in = 16'($urandom); ld_mar = 1'($urandom); ld_mdr = 1'($urandom);
      mio_en = 1'($urandom); r_w = 1'($urandom); mem_ack = 1'($urandom);
      mem_rdata = 16'($urandom);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("rst_mar",   32'(mem_addr),  32'd0);
    check("rst_mdr",   32'(mem_wdata), 32'd0);
    check("rst_ready", 32'(ready),     32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_req",   32'(mem_req),   32'd0);
    check("rst_err",   32'(err),       32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0; mem_ack = 1'b0;

    // Zero-wait read
    load(1'b1, 1'b0, 16'h3000);
    access(1'b0, 0, 16'hBEEF, 16'($urandom));
    idle_check(1'b1);
    check("read_beef", 32'(mem_wdata), 32'h0000BEEF);

    // Write with 3 wait states (ack on the timeout-limit cycle)
    load(1'b1, 1'b0, 16'h0042);
    load(1'b0, 1'b1, 16'h1234);
    access(1'b1, 3, 16'($urandom), 16'($urandom));
    idle_check(1'b0);
    check("write_mdr", 32'(mem_wdata), 32'h00001234);

    // Timeout, then err persists until the next start
    access(1'b0, 99, 16'($urandom), 16'($urandom));
    idle_check(1'b1);
    check("timeout_err", 32'(err), 32'd1);

    // Priority: ld_mar 5555 in the start cycle is ignored
    load(1'b1, 1'b0, 16'h0100);
    access(1'b0, 1, 16'hCAFE, 16'h5555);
    idle_check(1'b1);
    check("prio_mar", 32'(mem_addr), 32'h00000100);

    // Reset during the 2nd REQ cycle
    mio_en = 1'b1; r_w = 1'b0;
    @(posedge clk); #1;
    mio_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_req",   32'(mem_req),   32'd0);
    check("mid_rst_ready", 32'(ready),     32'd0);
    check("mid_rst_mar",   32'(mem_addr),  32'd0);
    check("mid_rst_mdr",   32'(mem_wdata), 32'd0);
    m_mar = '0; m_mdr = '0; m_err = 1'b0;
    @(posedge clk); #1;
    access(1'b0, 2, 16'h7777, 16'($urandom));
    idle_check(1'b1);

    // Randomised traffic
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1)
        load(1'($urandom), 1'($urandom), 16'($urandom));
      access(1'($urandom), $urandom_range(0, 6), 16'($urandom), 16'($urandom));
      idle_check(1'($urandom));
    end

    repeat (2) @(posedge clk);
    #1;
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
